// File: rtl/opcodes_pkg.sv
// Shared instruction-set definitions: opcode encoding, instruction field
// positions, datapath widths and the fetch state type.
// Imported by the fetch unit and by control.
package opcodes;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 8;

    // Instruction word layout: [15:12] opcode, [11:8] register, [7:0] immediate
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int REG_W = REG_MSB - REG_LSB + 1;
    localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

    // All 16 codes are defined so any IR[15:12] pattern maps to a legal value.
    typedef enum logic [OPC_W-1:0] {
        NOOP  = 4'h0,
        ADD   = 4'h1,
        SUB   = 4'h2,
        ANDR  = 4'h3,
        ORR   = 4'h4,
        XORR  = 4'h5,
        LUI   = 4'h6,
        LLI   = 4'h7,
        LDR   = 4'h8,
        STR   = 4'h9,
        JMP   = 4'hA,
        BZ    = 4'hB,
        WAIT1 = 4'hC,
        WAIT0 = 4'hD,
        OUTP  = 4'hE,
        HALT  = 4'hF
    } opcodes_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_sw_debounce.sv
// Two-flop synchroniser plus saturating debounce counter for a raw switch.
// Ports: Clock, Reset (async, active-high), In (raw async level), Out (clean level).
// Out follows In only after the synchronised level has differed for DEB_CYCLES edges.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic In,
    output logic Out
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             out_q,   out_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchroniser stages carry no logic between them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= In;
            sync2_q <= sync1_q;
        end
    end

    // cnt_q holds how many consecutive edges have already seen a difference;
    // the DEB_CYCLES-th differing edge flips the output instead of counting,
    // so the counter tops out at DEB_CYCLES-1 and can never wrap.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (sync2_q != out_q) begin
            if (cnt_q >= CNT_LAST) begin
                out_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign Out = out_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC and IR registers, FILL/RUN state machine, debounced Sw8.
// Ports: Clock, Reset, PcWait (stall), ProgData (ROM word) in; ProgAddr (PC), OpCode,
// RegAddr, Imm (IR fields), Sw8 (clean switch), IrValid out. One cycle ProgAddr->OpCode.
module fetch_unit
    import opcodes::*;
#(
    parameter int PROG_LEN   = 256,
    parameter int DEB_CYCLES = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               PcWait,
    input  logic [INSTR_W-1:0] ProgData,
    input  logic               Sw8Raw,
    output logic [PC_W-1:0]    ProgAddr,
    output opcodes_t           OpCode,
    output logic [REG_W-1:0]   RegAddr,
    output logic [IMM_W-1:0]   Imm,
    output logic               Sw8,
    output logic               IrValid
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q,    pc_d;
    logic [INSTR_W-1:0] ir_q,    ir_d;
    logic [PC_W-1:0]    pc_inc;

    // Control sees only the registered, debounced Sw8, so a stall decision
    // never depends combinationally on the raw switch.
    sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw8_deb (
        .Clock (Clock),
        .Reset (Reset),
        .In    (Sw8Raw),
        .Out   (Sw8)
    );

    // Wrap straight to 0 so the program loops without a bubble, even when
    // PROG_LEN is not a power of two.
    assign pc_inc = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (state_q == FILL) begin
            // PC is 0 here, so ProgData is word 0; stall requests are ignored
            // because control has no valid instruction to stall on yet.
            ir_d    = ProgData;
            pc_d    = pc_inc;
            state_d = RUN;
        end else if (!PcWait) begin
            ir_d = ProgData;
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FILL;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign ProgAddr = pc_q;
    assign IrValid  = (state_q == RUN);
    assign RegAddr  = ir_q[REG_MSB:REG_LSB];
    assign Imm      = ir_q[IMM_MSB:IMM_LSB];
    // Until IR holds a real instruction, control must see a harmless NOOP.
    assign OpCode   = (state_q == RUN) ? opcodes_t'(ir_q[OPC_MSB:OPC_LSB]) : NOOP;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import opcodes::*;

    localparam int PLEN = 256;
    localparam int DEB  = 4;

    logic        Clock;
    logic        Reset;
    logic        PcWait;
    logic [15:0] ProgData;
    logic        Sw8Raw;
    logic [7:0]  ProgAddr;
    opcodes_t    OpCode;
    logic [3:0]  RegAddr;
    logic [7:0]  Imm;
    logic        Sw8;
    logic        IrValid;

    logic [15:0] rom [PLEN];

    fetch_unit #(
        .PROG_LEN   (PLEN),
        .DEB_CYCLES (DEB)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .PcWait   (PcWait),
        .ProgData (ProgData),
        .Sw8Raw   (Sw8Raw),
        .ProgAddr (ProgAddr),
        .OpCode   (OpCode),
        .RegAddr  (RegAddr),
        .Imm      (Imm),
        .Sw8      (Sw8),
        .IrValid  (IrValid)
    );

    // Combinational program ROM
    assign ProgData = rom[ProgAddr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: program counter, fetched word, valid flag, and the
    // switch as "raw value seen two edges late, flipped after DEB differing edges".
    int          m_pc;
    logic [15:0] m_ir;
    bit          m_valid;
    bit          m_q[$];
    bit          m_sw8;
    int          m_run;

    task automatic model_reset();
        m_pc    = 0;
        m_ir    = 16'h0000;
        m_valid = 0;
        m_q     = {1'b0, 1'b0};
        m_sw8   = 0;
        m_run   = 0;
    endtask

    task automatic model_edge(input bit w, input bit r);
        bit seen;
        if (!m_valid) begin
            m_ir    = rom[0];
            m_pc    = 1;
            m_valid = 1;
        end else if (!w) begin
            m_ir = rom[m_pc];
            m_pc = (m_pc + 1) % PLEN;
        end
        seen = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(r);
        if (seen != m_sw8) begin
            m_run++;
            if (m_run == DEB) begin
                m_sw8 = seen;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_all();
        check_eq("addr",  ProgAddr, m_pc);
        check_eq("opc",   OpCode,   m_valid ? m_ir[15:12] : 4'h0);
        check_eq("reg",   RegAddr,  m_ir[11:8]);
        check_eq("imm",   Imm,      m_ir[7:0]);
        check_eq("valid", IrValid,  m_valid);
        check_eq("sw8",   Sw8,      m_sw8);
    endtask

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic step(input bit w, input bit r);
        PcWait = w;
        Sw8Raw = r;
        @(posedge Clock);
        model_edge(w, r);
        #1;
        check_all();
    endtask

    initial begin
        int  g;
        int  n;
        bit  raw;
        bit  w;
        logic [7:0] wrap_exp [3];

        for (int i = 0; i < PLEN; i++) rom[i] = 16'($urandom);
        rom[0][15:12]   = ADD;
        rom[1][15:12]   = LUI;
        rom[100][15:12] = WAIT1;

        Reset  = 1'b1;
        PcWait = 1'b0;
        Sw8Raw = 1'b0;
        model_reset();
        #12;
        check_eq("rst_addr", ProgAddr, 0);
        check_eq("rst_opc",  OpCode,   NOOP);
        check_all();
        Reset = 1'b0;

        // First fetch after reset release
        step(0, 0);
        check_eq("e1_opc",  OpCode,   ADD);
        check_eq("e1_vld",  IrValid,  1);
        check_eq("e1_addr", ProgAddr, 1);
        step(0, 0);
        check_eq("e2_opc",  OpCode,   LUI);
        check_eq("e2_addr", ProgAddr, 2);

        // Five-cycle stall at PC=7
        g = 0;
        while (m_pc != 7 && g < 300) begin step(0, 0); g++; end
        check_eq("at7", ProgAddr, 7);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            check_eq("stall_addr", ProgAddr, 7);
            check_eq("stall_opc",  OpCode,   rom[6][15:12]);
        end
        step(0, 0);
        check_eq("unstall_addr", ProgAddr, 8);

        // Random stalls and switch activity
        raw = 0;
        for (int i = 0; i < 700; i++) begin
            w = ($urandom_range(9) < 3);
            if ($urandom_range(7) == 0) raw = ~raw;
            step(w, raw);
        end

        // Glitch shorter than the debounce window
        for (int i = 0; i < 12; i++) step(0, 0);
        check_eq("settle_sw8", Sw8, 0);
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            check_eq("glitch_sw8", Sw8, 0);
        end
        // Held rise: latency is synchroniser plus debounce window
        n = 0;
        do begin
            step(0, 1);
            n++;
        end while (Sw8 !== 1'b1 && n < 20);
        check_eq("sw8_latency", n, 2 + DEB);

        // Wrap 254 -> 255 -> 0 -> 1
        g = 0;
        while (m_pc != 254 && g < 400) begin step(0, 1); g++; end
        check_eq("at254", ProgAddr, 254);
        wrap_exp[0] = 8'd255;
        wrap_exp[1] = 8'd0;
        wrap_exp[2] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            check_eq("wrap_addr", ProgAddr, wrap_exp[i]);
            check_eq("wrap_vld",  IrValid,  1);
        end

        // WAIT1 with control emulated: stall while IR=WAIT1 and Sw8 high
        g = 0;
        while (m_pc != 101 && g < 400) begin step(0, 1); g++; end
        check_eq("wait_opc", OpCode, WAIT1);
        check_eq("wait_sw8", Sw8,    1);
        n = 0;
        do begin
            w = (m_valid && m_ir[15:12] == WAIT1 && m_sw8);
            step(w, 0);
            n++;
        end while (ProgAddr == 8'd101 && n < 30);
        check_eq("wait_edges", n, 2 + DEB + 1);
        check_eq("wait_addr",  ProgAddr, 102);

        // Asynchronous reset mid-stall and mid-debounce at PC=40
        g = 0;
        while (m_pc != 40 && g < 400) begin step(0, 1); g++; end
        check_eq("at40",     ProgAddr, 40);
        check_eq("pre_sw8",  Sw8,      1);
        for (int i = 0; i < 3; i++) step(1, 0);
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        check_eq("arst_addr", ProgAddr, 0);
        check_eq("arst_opc",  OpCode,   NOOP);
        check_eq("arst_sw8",  Sw8,      0);
        check_all();
        #1;
        Reset = 1'b0;
        // PcWait must be ignored on the fill edge
        step(1, 0);
        check_eq("refill_opc",  OpCode,   ADD);
        check_eq("refill_addr", ProgAddr, 1);
        check_eq("refill_vld",  IrValid,  1);
        for (int i = 0; i < 20; i++) step($urandom_range(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PROG_LEN, default 256: number of program words; PC wraps after PROG_LEN-1.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: cycles Sw8 must be stable before the debounced value changes.
REQ-003 SHALL have port Clock  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PcWait  input  1  stall request from control; holds PC and IR.
REQ-006 SHALL have port ProgData  input  16  instruction word read combinationally from program ROM at ProgAddr.
REQ-007 SHALL have port Sw8Raw  input  1  raw, asynchronous switch input.
REQ-008 SHALL have port ProgAddr  output  8  current PC, drives program ROM address.
REQ-009 SHALL have port OpCode  output  opcodes::opcodes_t  IR[15:12], feeds control.
REQ-010 SHALL have port RegAddr  output  4  IR[11:8], register-file address.
REQ-011 SHALL have port Imm  output  8  IR[7:0], immediate operand.
REQ-012 SHALL have port Sw8  output  1  synchronised, debounced switch, feeds control.
REQ-013 SHALL have port IrValid  output  1  high when IR holds a fetched instruction.

Function
REQ-014 SHALL use states FILL and RUN; FILL is entered on reset, and RUN is entered on the first clock edge after reset deassertion.
REQ-015 In FILL, the block SHALL load IR from ProgData at PC=0, set PC to 1, and drive IrValid=0, with OpCode forced to NOOP.
REQ-016 In RUN with PcWait=0, on each edge the block SHALL set IR <= ProgData and PC <= PC+1, giving one-cycle latency from ProgAddr to OpCode.
REQ-017 In RUN with PcWait=1, PC and IR SHALL hold their values, and IrValid SHALL stay 1.
REQ-018 PcWait SHALL be ignored in FILL.
REQ-019 PC SHALL wrap from PROG_LEN-1 to 0 with no bubble; the increment SHALL be 8-bit modulo PROG_LEN.
REQ-020 The Sw8 path SHALL consist of a 2-flop synchroniser followed by a debounce counter.
REQ-021 Sw8 SHALL change only after the synchronised value has differed from Sw8 for DEB_CYCLES consecutive cycles; any return to equality SHALL clear the counter.
REQ-022 Minimum Sw8Raw-to-Sw8 latency SHALL be 2+DEB_CYCLES cycles.
REQ-023 The debounce counter SHALL saturate and never wrap.
REQ-024 If PcWait and a Sw8 change occur in the same cycle, the stall decision SHALL use the registered Sw8 value, with no combinational path from Sw8Raw.
REQ-025 Outputs SHALL be registered or direct IR slices; the only combinational input-to-output path SHALL be the OpCode NOOP force, which depends on state only.

Reset
REQ-026 Reset SHALL asynchronously set PC=0, IR=16'h0000, state=FILL, synchroniser flops=0, debounce counter=0, and Sw8=0.
REQ-027 During reset, outputs SHALL be ProgAddr=0, OpCode=NOOP, RegAddr=0, Imm=0, IrValid=0, Sw8=0.
REQ-028 Reset asserted mid-stall or mid-debounce SHALL abort immediately, and no partial update SHALL survive.
REQ-029 After Reset deasserts, the first valid instruction SHALL appear after exactly 1 clock edge.

Structure
REQ-030 INSTR_W=16, PC_W=8, the field bit positions, and fetch_state_t {FILL, RUN} SHALL be added to the shared opcodes package; opcodes_t SHALL be reused from it.
REQ-031 The synchroniser and debounce logic SHALL be one sub-module, sw_debounce (ports Clock, Reset, In, Out; parameter DEB_CYCLES).
REQ-032 fetch_unit SHALL instantiate exactly one sw_debounce; the remaining logic SHALL be the PC/IR registers and the state machine.

Verification
REQ-033 Reset release with ROM[0]=ADD, ROM[1]=LUI -> edge 1: OpCode=ADD, IrValid=1, ProgAddr=1; edge 2: OpCode=LUI, ProgAddr=2.
REQ-034 PcWait=1 for 5 cycles at PC=7 -> ProgAddr stays 7 and OpCode is unchanged; PcWait=0 -> ProgAddr=8 on the next edge.
REQ-035 PROG_LEN=256, run from PC=254 -> ProgAddr sequence 254, 255, 0, 1, with IrValid continuously 1.
REQ-036 Sw8Raw glitch high for 3 cycles (DEB_CYCLES=4) -> Sw8 stays 0; Sw8Raw held high -> Sw8=1 exactly 6 cycles after the rise.
REQ-037 Reset pulsed asynchronously, between edges, during a stall at PC=40 -> immediate ProgAddr=0, OpCode=NOOP, Sw8=0; normal fill follows.
REQ-038 IR=WAIT1 with Sw8 debounced high, then Sw8Raw dropped -> fetch stays stalled until Sw8=0, then PC advances on the next edge.
